// File: rtl/pcie_tlp_pkg.sv
// Shared definitions for the PCIe TX formatter/arbiter.
// - TLP fmt/type byte constants for CplD, MRd64 and MWr64.
// - FSM state and source-select enums.
// - Header-DW builder functions.
package pcie_tlp_pkg;

  localparam logic [7:0] CPLD  = 8'h4A;
  localparam logic [7:0] MRD64 = 8'h20;
  localparam logic [7:0] MWR64 = 8'h60;

  typedef enum logic [3:0] {
    StIdle, StCpl0, StCpl1, StCpl2, StRrq0, StRrq1, StWrh0, StWrh1, StWrd, StDone
  } tx_state_e;

  typedef enum logic [1:0] {SrcCpl, SrcRd, SrcWr} tx_src_e;

  // DW0: fmt/type in the top byte, length in the low 10 bits.
  function automatic logic [31:0] hdr_dw0(input logic [7:0] fmt_type, input logic [9:0] len);
    return {fmt_type, 14'd0, len};
  endfunction

  // Completion DW1: completer ID, status 0, BCM 0, byte count.
  function automatic logic [31:0] cpl_hdr_dw1(input logic [15:0] id, input logic [11:0] byte_count);
    return {id, 3'b000, 1'b0, byte_count};
  endfunction

  // Completion DW2: requester ID + tag, then the 7-bit lower address (qword aligned).
  function automatic logic [31:0] cpl_hdr_dw2(input logic [23:0] rid_tag,
                                              input logic [3:0]  lower_addr);
    return {rid_tag, 1'b0, lower_addr, 3'b000};
  endfunction

  // Request DW1: requester ID, tag, last/first byte enables.
  function automatic logic [31:0] req_hdr_dw1(input logic [15:0] id, input logic [7:0] tag,
                                              input logic [7:0] byte_en);
    return {id, tag, byte_en};
  endfunction

endpackage

// File: rtl/endian_swap64.sv
// Byte reversal of each 32-bit half of a qword (halves stay in place).
// Ports: qword - input qword; swapped - {bswap(qword[63:32]), bswap(qword[31:0])}.
module endian_swap64 (
  input  logic [63:0] qword,
  output logic [63:0] swapped
);

  assign swapped = {qword[39:32], qword[47:40], qword[55:48], qword[63:56],
                    qword[7:0],   qword[15:8],  qword[23:16], qword[31:24]};

endmodule

// File: rtl/pcie_tx_arb.sv
// PCIe TX TLP formatter/arbiter onto a 64-bit AXI-stream.
// Sources: read completions (CplD, strict priority), DMA read requests (MRd64) and DMA write
// bursts (MWr64); the two request sources alternate round-robin.
// Ports:
//   clock, reset            - single clock, synchronous active-high reset
//   pcie_id                 - requester/completer ID
//   read_completion_*       - completion source (valid/fields in, ready pulse out)
//   read_request_*          - read request source (valid/fields in, ready pulse out)
//   write_request_*         - write source (valid/addr/data in, per-qword accepted, ready out)
//   axis_tx_*               - registered AXI-stream towards the hard core
module pcie_tx_arb
  import pcie_tlp_pkg::*;
#(
  parameter int unsigned WR_BURST_QW = 16,
  parameter int unsigned RD_REQ_DW   = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pcie_id,
  input  logic        read_completion_valid,
  input  logic [23:0] read_completion_rid_tag,
  input  logic [3:0]  read_completion_lower_addr,
  input  logic [63:0] read_completion_data,
  output logic        read_completion_ready,
  input  logic        read_request_valid,
  input  logic [63:0] read_request_address,
  input  logic [7:0]  read_request_tag,
  output logic        read_request_ready,
  input  logic        write_request_valid,
  input  logic [63:0] write_request_address,
  input  logic [63:0] write_request_data,
  output logic        write_request_accepted,
  output logic        write_request_ready,
  input  logic        axis_tx_tready,
  output logic [63:0] axis_tx_tdata,
  output logic [7:0]  axis_tx_tkeep,
  output logic        axis_tx_tlast,
  output logic        axis_tx_tvalid
);

  localparam int unsigned     CntW    = $clog2(WR_BURST_QW) + 1;
  localparam logic [9:0]      RdLen   = 10'(RD_REQ_DW % 1024);
  localparam logic [9:0]      WrLen   = 10'((2 * WR_BURST_QW) % 1024);
  localparam logic [CntW-1:0] LastCnt = CntW'(WR_BURST_QW);

  tx_state_e       state_q, state_d;
  tx_src_e         src_q, src_d, rr_last_q, rr_last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     tdata_q, tdata_d;
  logic [7:0]      tkeep_q, tkeep_d;
  logic            tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic            cpl_rdy_q, cpl_rdy_d, rd_rdy_q, rd_rdy_d, wr_rdy_q, wr_rdy_d;
  logic            advance, load_data, finish;
  logic [63:0]     cpl_swapped, wr_swapped;

  endian_swap64 u_cpl_swap (.qword(read_completion_data), .swapped(cpl_swapped));
  endian_swap64 u_wr_swap  (.qword(write_request_data),   .swapped(wr_swapped));

  assign advance = !tvalid_q || axis_tx_tready;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tlast_d   = tlast_q;
    tvalid_d  = tvalid_q;
    cpl_rdy_d = 1'b0;
    rd_rdy_d  = 1'b0;
    wr_rdy_d  = 1'b0;
    load_data = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d    = '0;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (read_completion_valid) begin
          tdata_d  = {cpl_hdr_dw1(pcie_id, 12'd8), hdr_dw0(CPLD, 10'd2)};
          tkeep_d  = 8'hFF;
          tvalid_d = 1'b1;
          src_d    = SrcCpl;
          state_d  = StCpl0;
        end else if (read_request_valid && (!write_request_valid || rr_last_q != SrcRd)) begin
          tdata_d  = {req_hdr_dw1(pcie_id, read_request_tag, 8'hFF), hdr_dw0(MRD64, RdLen)};
          tkeep_d  = 8'hFF;
          tvalid_d = 1'b1;
          src_d    = SrcRd;
          state_d  = StRrq0;
        end else if (write_request_valid) begin
          tdata_d  = {req_hdr_dw1(pcie_id, 8'h00, 8'hFF), hdr_dw0(MWR64, WrLen)};
          tkeep_d  = 8'hFF;
          tvalid_d = 1'b1;
          src_d    = SrcWr;
          state_d  = StWrh0;
        end
      end
      StCpl0: if (advance) begin
        tdata_d = {cpl_swapped[31:0],
                   cpl_hdr_dw2(read_completion_rid_tag, read_completion_lower_addr)};
        state_d = StCpl1;
      end
      StCpl1: if (advance) begin
        tdata_d = {32'h0, cpl_swapped[63:32]};
        tkeep_d = 8'h0F;
        tlast_d = 1'b1;
        state_d = StCpl2;
      end
      StRrq0: if (advance) begin
        tdata_d = {read_request_address[31:0], read_request_address[63:32]};
        tlast_d = 1'b1;
        state_d = StRrq1;
      end
      StWrh0: if (advance) begin
        tdata_d = {write_request_address[31:0], write_request_address[63:32]};
        state_d = StWrh1;
      end
      StWrh1, StWrd: if (advance) begin
        if (tlast_q) begin
          finish = 1'b1;
        end else begin
          load_data = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
          tdata_d   = wr_swapped;
          tlast_d   = (cnt_d == LastCnt);
          state_d   = StWrd;
        end
      end
      StCpl2, StRrq1: if (advance) finish = 1'b1;
      StDone: begin
        // Completions never take a round-robin turn from the request sources.
        if (src_q != SrcCpl) rr_last_d = src_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (finish) begin
      tvalid_d  = 1'b0;
      tlast_d   = 1'b0;
      cpl_rdy_d = (src_q == SrcCpl);
      rd_rdy_d  = (src_q == SrcRd);
      wr_rdy_d  = (src_q == SrcWr);
      state_d   = StDone;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      src_q     <= SrcRd;
      rr_last_q <= SrcWr;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      cpl_rdy_q <= 1'b0;
      rd_rdy_q  <= 1'b0;
      wr_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      cpl_rdy_q <= cpl_rdy_d;
      rd_rdy_q  <= rd_rdy_d;
      wr_rdy_q  <= wr_rdy_d;
    end
  end

  assign axis_tx_tdata          = tdata_q;
  assign axis_tx_tkeep          = tkeep_q;
  assign axis_tx_tlast          = tlast_q;
  assign axis_tx_tvalid         = tvalid_q;
  assign read_completion_ready  = cpl_rdy_q;
  assign read_request_ready     = rd_rdy_q;
  assign write_request_ready    = wr_rdy_q;
  // Strobe for the edge that loads a data qword; the qword is not taken while in reset.
  assign write_request_accepted = load_data && !reset;

endmodule

// File: tb/tb_pcie_tx_arb.sv
module tb_pcie_tx_arb;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pcie_id = 16'hBEEF;
  logic        read_completion_valid = 1'b0;
  logic [23:0] read_completion_rid_tag = '0;
  logic [3:0]  read_completion_lower_addr = '0;
  logic [63:0] read_completion_data = '0;
  logic        read_completion_ready;
  logic        read_request_valid = 1'b0;
  logic [63:0] read_request_address = 64'h0000_0001_2345_6780;
  logic [7:0]  read_request_tag = 8'h5A;
  logic        read_request_ready;
  logic        write_request_valid = 1'b0;
  logic [63:0] write_request_address = 64'h0000_00AB_CDEF_0000;
  logic [63:0] write_request_data = '0;
  logic        write_request_accepted;
  logic        write_request_ready;
  logic        axis_tx_tready = 1'b1;
  logic [63:0] axis_tx_tdata;
  logic [7:0]  axis_tx_tkeep;
  logic        axis_tx_tlast;
  logic        axis_tx_tvalid;

  // Second instance for the length-0 encodings.
  logic        reset_b = 1'b1;
  logic        rd_valid_b = 1'b0;
  logic        wr_valid_b = 1'b0;
  logic        cpl_ready_b, rd_ready_b, wr_acc_b, wr_ready_b;
  logic [63:0] tdata_b;
  logic [7:0]  tkeep_b;
  logic        tlast_b, tvalid_b;

  always #5 clock = ~clock;

  pcie_tx_arb #(.WR_BURST_QW(4), .RD_REQ_DW(128)) dut (
    .clock(clock), .reset(reset), .pcie_id(pcie_id),
    .read_completion_valid(read_completion_valid),
    .read_completion_rid_tag(read_completion_rid_tag),
    .read_completion_lower_addr(read_completion_lower_addr),
    .read_completion_data(read_completion_data),
    .read_completion_ready(read_completion_ready),
    .read_request_valid(read_request_valid), .read_request_address(read_request_address),
    .read_request_tag(read_request_tag), .read_request_ready(read_request_ready),
    .write_request_valid(write_request_valid), .write_request_address(write_request_address),
    .write_request_data(write_request_data), .write_request_accepted(write_request_accepted),
    .write_request_ready(write_request_ready),
    .axis_tx_tready(axis_tx_tready), .axis_tx_tdata(axis_tx_tdata),
    .axis_tx_tkeep(axis_tx_tkeep), .axis_tx_tlast(axis_tx_tlast),
    .axis_tx_tvalid(axis_tx_tvalid)
  );

  pcie_tx_arb #(.WR_BURST_QW(512), .RD_REQ_DW(1024)) dut_len0 (
    .clock(clock), .reset(reset_b), .pcie_id(pcie_id),
    .read_completion_valid(1'b0), .read_completion_rid_tag(24'h0),
    .read_completion_lower_addr(4'h0), .read_completion_data(64'h0),
    .read_completion_ready(cpl_ready_b),
    .read_request_valid(rd_valid_b), .read_request_address(64'h0),
    .read_request_tag(8'h00), .read_request_ready(rd_ready_b),
    .write_request_valid(wr_valid_b), .write_request_address(64'h0),
    .write_request_data(64'h0), .write_request_accepted(wr_acc_b),
    .write_request_ready(wr_ready_b),
    .axis_tx_tready(1'b1), .axis_tx_tdata(tdata_b), .axis_tx_tkeep(tkeep_b),
    .axis_tx_tlast(tlast_b), .axis_tx_tvalid(tvalid_b)
  );

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    cpl_rdy_cnt = 0, rd_rdy_cnt = 0, wr_rdy_cnt = 0, acc_cnt = 0;
  int    last_tlast_cyc = -100;
  int    gaps[$];
  beat_t exp_q[$];
  logic  toggle_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [63:0] data, input logic [7:0] keep, input logic last);
    beat_t b;
    b.data = data;
    b.keep = keep;
    b.last = last;
    exp_q.push_back(b);
  endtask

  function automatic logic [63:0] wpat(input int k);
    return {32'h11223344, 24'h556677, 8'(k)};
  endfunction

  task automatic push_mwr4();
    push({32'hBEEF00FF, 32'h60000008}, 8'hFF, 1'b0);
    push({32'hCDEF0000, 32'h000000AB}, 8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) push({32'h44332211, 8'(k), 24'h776655}, 8'hFF, k == 3);
  endtask

  task automatic push_mrd();
    push({32'hBEEF5AFF, 32'h20000080}, 8'hFF, 1'b0);
    push({32'h23456780, 32'h00000001}, 8'hFF, 1'b1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs until each ready count reaches its target, dropping each valid once its source is done.
  task automatic run_until(input int cpl_t, input int rd_t, input int wr_t, input string name);
    int n = 0;
    while (!(cpl_rdy_cnt >= cpl_t && rd_rdy_cnt >= rd_t && wr_rdy_cnt >= wr_t) && n < 400) begin
      tick();
      n++;
      if (cpl_rdy_cnt >= cpl_t) read_completion_valid = 1'b0;
      if (rd_rdy_cnt >= rd_t) read_request_valid = 1'b0;
      if (wr_rdy_cnt >= wr_t) write_request_valid = 1'b0;
    end
    check({name, "_done_in_time"}, 73'(n < 400), 73'(1));
  endtask

  task automatic wait_b(input string name);
    int n = 0;
    while (!tvalid_b && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({name, "_tvalid"}, 73'(tvalid_b), 73'(1));
  endtask

  // tready source: constant 1, or toggling every cycle when enabled.
  initial forever begin
    tick();
    axis_tx_tready = toggle_en ? ~axis_tx_tready : 1'b1;
  end

  // Write data source: advances one qword per accepted strobe, restarts per TLP/reset.
  initial begin
    int   widx = 0;
    logic acc_s, rdy_s, rst_s;
    write_request_data = wpat(0);
    forever begin
      @(negedge clock);
      acc_s = write_request_accepted;
      rdy_s = write_request_ready;
      rst_s = reset;
      tick();
      if (rst_s || rdy_s) widx = 0;
      else if (acc_s) widx++;
      write_request_data = wpat(widx);
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability, counts pulses.
  initial begin
    logic  prev_tvalid = 1'b0;
    logic  held_valid = 1'b0;
    beat_t held, cur, e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_tvalid = 1'b0;
        held_valid  = 1'b0;
        continue;
      end
      cur = {axis_tx_tdata, axis_tx_tkeep, axis_tx_tlast};
      if (axis_tx_tvalid && !prev_tvalid) gaps.push_back(cyc - last_tlast_cyc);
      prev_tvalid = axis_tx_tvalid;
      if (held_valid) check("stall_hold", {axis_tx_tvalid, cur[72:1]}, {1'b1, held[72:1]});
      held_valid = axis_tx_tvalid && !axis_tx_tready;
      held = cur;
      if (axis_tx_tvalid && axis_tx_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected none (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
        end
        if (axis_tx_tlast) last_tlast_cyc = cyc;
      end
      if (read_completion_ready) cpl_rdy_cnt++;
      if (read_request_ready) rd_rdy_cnt++;
      if (write_request_ready) wr_rdy_cnt++;
      if (write_request_accepted) acc_cnt++;
    end
  end

  initial begin
    int base, n;
    repeat (3) tick();
    @(negedge clock);
    check("rst_tvalid", 73'(axis_tx_tvalid), 73'(0));
    check("rst_tlast", 73'(axis_tx_tlast), 73'(0));
    check("rst_tdata", 73'(axis_tx_tdata), 73'(0));
    check("rst_tkeep", 73'(axis_tx_tkeep), 73'(0));
    check("rst_pulses", 73'({read_completion_ready, read_request_ready, write_request_ready,
                             write_request_accepted}), 73'(0));
    tick();
    reset   = 1'b0;
    reset_b = 1'b0;
    repeat (2) tick();

    // Single CplD.
    read_completion_data       = 64'h0011223344556677;
    read_completion_rid_tag    = 24'h123456;
    read_completion_lower_addr = 4'h5;
    push({32'hBEEF0008, 32'h4A000002}, 8'hFF, 1'b0);
    push({32'h77665544, 32'h12345628}, 8'hFF, 1'b0);
    push({32'h00000000, 32'h33221100}, 8'h0F, 1'b1);
    base = cpl_rdy_cnt;
    read_completion_valid = 1'b1;
    @(negedge clock);
    check("lat_before", 73'(axis_tx_tvalid), 73'(0));
    @(negedge clock);
    check("lat_after", 73'(axis_tx_tvalid), 73'(1));
    run_until(base + 1, rd_rdy_cnt, wr_rdy_cnt, "cpl");
    repeat (4) tick();
    check("cpl_one_ready", 73'(cpl_rdy_cnt - base), 73'(1));

    // Round-robin: MRd, MWr, MRd, MWr.
    push_mrd();
    push_mwr4();
    push_mrd();
    push_mwr4();
    read_request_valid  = 1'b1;
    write_request_valid = 1'b1;
    run_until(cpl_rdy_cnt, rd_rdy_cnt + 2, wr_rdy_cnt + 2, "rr");
    repeat (3) tick();

    // MWr with tready toggling.
    base = acc_cnt;
    push_mwr4();
    toggle_en = 1'b1;
    write_request_valid = 1'b1;
    run_until(cpl_rdy_cnt, rd_rdy_cnt, wr_rdy_cnt + 1, "mwr_stall");
    toggle_en = 1'b0;
    repeat (3) tick();
    check("accepted_pulses", 73'(acc_cnt - base), 73'(4));

    // Completion arrives in MWr data phase with a read pending.
    push_mwr4();
    base = acc_cnt;
    write_request_valid = 1'b1;
    n = 0;
    while (acc_cnt == base && n < 50) begin
      tick();
      n++;
    end
    check("mwr_data_phase", 73'(acc_cnt > base), 73'(1));
    gaps.delete();
    read_completion_data       = 64'hDEADBEEF_CAFEF00D;
    read_completion_rid_tag    = 24'hABCDEF;
    read_completion_lower_addr = 4'hF;
    push({32'hBEEF0008, 32'h4A000002}, 8'hFF, 1'b0);
    push({32'h0DF0FECA, 32'hABCDEF78}, 8'hFF, 1'b0);
    push({32'h00000000, 32'hEFBEADDE}, 8'h0F, 1'b1);
    push_mrd();
    read_completion_valid = 1'b1;
    read_request_valid    = 1'b1;
    run_until(cpl_rdy_cnt + 1, rd_rdy_cnt + 1, wr_rdy_cnt + 1, "cpl_mid");
    check("gap_count", 73'(gaps.size() >= 2), 73'(1));
    if (gaps.size() >= 2) begin
      check("gap_cpl", 73'(gaps[0]), 73'(3));
      check("gap_mrd", 73'(gaps[1]), 73'(3));
    end
    repeat (3) tick();

    // Reset while the first data beat (beat 3) of an MWr is on the bus.
    push({32'hBEEF00FF, 32'h60000008}, 8'hFF, 1'b0);
    push({32'hCDEF0000, 32'h000000AB}, 8'hFF, 1'b0);
    write_request_valid = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("hdr_before_reset", 73'(exp_q.size()), 73'(0));
    base  = wr_rdy_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_mwr4();
    @(negedge clock);
    check("rst_mid_tvalid", 73'(axis_tx_tvalid), 73'(0));
    check("rst_mid_tlast", 73'(axis_tx_tlast), 73'(0));
    check("rst_mid_no_ready", 73'(wr_rdy_cnt - base), 73'(0));
    run_until(cpl_rdy_cnt, rd_rdy_cnt, base + 1, "mwr_restart");
    repeat (3) tick();
    check("queue_drained", 73'(exp_q.size()), 73'(0));

    // Length-0 encodings.
    rd_valid_b = 1'b1;
    wait_b("len0_mrd");
    check("len0_mrd_dw0", 73'(tdata_b[31:0]), 73'(32'h20000000));
    tick();
    reset_b    = 1'b1;
    rd_valid_b = 1'b0;
    repeat (2) tick();
    reset_b    = 1'b0;
    wr_valid_b = 1'b1;
    tick();
    wait_b("len0_mwr");
    check("len0_mwr_dw0", 73'(tdata_b[31:0]), 73'(32'h60000000));
    tick();
    reset_b    = 1'b1;
    wr_valid_b = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
